// File: rtl/cbus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_rr_arbiter_pkg
//  Purpose  : Shared cbus types, arbitration mode/state enums and a small
//             index-wrapping helper used by the cbus arbiter.
//  Contents : cbus_req_t, cbus_resp_t, arb_mode_e, cbus_arb_state_e,
//             wrap_inc()
//  Revision : 1.0 - initial release
// ============================================================================
package cbus_rr_arbiter_pkg;

  localparam int c_CBUS_ADDR_W = 32;
  localparam int c_CBUS_DATA_W = 32;

  // Master-side request: held stable by the master until the last beat.
  typedef struct packed {
    logic                       valid;
    logic                       write;
    logic [c_CBUS_ADDR_W-1:0]   addr;
    logic [c_CBUS_DATA_W-1:0]   wdata;
    logic [c_CBUS_DATA_W/8-1:0] wstrb;
  } cbus_req_t;

  // Downstream response; ready && last marks the final beat of a burst.
  typedef struct packed {
    logic                     ready;
    logic                     last;
    logic [c_CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [0:0] {
    RR   = 1'b0,
    PRIO = 1'b1
  } arb_mode_e;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } cbus_arb_state_e;

  // (idx + 1) mod n without requiring n to be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_rr_arbiter_rr_pick
//  Purpose  : Rotating first-one picker. Returns the first set bit of req at
//             or after ptr, wrapping around, as both one-hot and index.
//  Ports    : req    in  N      request vector
//             ptr    in  IDX_W  start position
//             any    out 1      at least one request set
//             onehot out N      one-hot winner (zero when none)
//             idx    out IDX_W  winner index (zero when none)
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  localparam int c_POS_W = $clog2(2 * N);

  // Two copies of req side by side: masking off everything below ptr leaves
  // the upper copy to supply the wrapped-around requests.
  logic [2*N-1:0]     w_dbl;
  logic [2*N-1:0]     w_masked;
  logic [c_POS_W-1:0] w_pos;
  logic [c_POS_W-1:0] w_pos_mod;
  logic               w_found;

  assign w_dbl    = {req, req};
  assign w_masked = w_dbl & ({(2*N){1'b1}} << ptr);

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!w_found && w_masked[i]) begin
        w_found = 1'b1;
        w_pos   = c_POS_W'(i);
      end
    end
  end

  // A hit in the upper copy maps back onto the same physical input.
  assign w_pos_mod = (w_pos >= c_POS_W'(N)) ? (w_pos - c_POS_W'(N)) : w_pos;

  assign any    = |req;
  assign idx    = IDX_W'(w_pos_mod);
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_rr_arbiter
//  Purpose  : Zero-latency N-to-1 cbus arbiter. Grants combinationally in
//             IDLE, locks the owner until the burst's last beat (or until the
//             owner drops valid), then rotates the pointer / ages waiters.
//             MODE 0 = round-robin, MODE 1 = fixed priority with aging.
//  Ports    : clk    in  1                 clock
//             reset  in  1                 synchronous, active-low reset
//             ireqs  in  cbus_req_t[N]     master requests
//             iresps out cbus_resp_t[N]    responses, owner only
//             oreq   out cbus_req_t        forwarded request
//             oresp  in  cbus_resp_t       downstream response
//             grant  out N                 one-hot current owner
//             busy   out 1                 burst locked
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS   = 2,
  parameter int MODE         = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  cbus_req_t             ireqs  [NUM_INPUTS],
  output cbus_resp_t            iresps [NUM_INPUTS],
  output cbus_req_t             oreq,
  input  cbus_resp_t            oresp,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  busy
);

  localparam int                 c_IDX_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int                 c_AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(STARVE_LIMIT);
  localparam bit                 c_PRIO    = (MODE == int'(PRIO));

  cbus_arb_state_e          r_state;
  logic [c_IDX_W-1:0]       r_owner;
  logic [c_IDX_W-1:0]       r_ptr;
  logic [c_AGE_W-1:0]       r_age [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]    r_start_valid;

  logic [NUM_INPUTS-1:0]    w_valid;
  logic [NUM_INPUTS-1:0]    w_pick_req;
  logic [c_IDX_W-1:0]       w_pick_ptr;
  logic                     w_win_any;
  logic [NUM_INPUTS-1:0]    w_win_onehot;
  logic [c_IDX_W-1:0]       w_win_idx;
  logic                     w_locked;
  logic                     w_done;
  logic                     w_owner_valid;
  logic [c_IDX_W-1:0]       w_sel_idx;
  logic [NUM_INPUTS-1:0]    w_sel_start;
  logic                     w_sel_active;
  logic                     w_release;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
    assign w_valid[gi] = ireqs[gi].valid;
  end

  // Priority mode reuses the rotating picker with a zero pointer; inputs that
  // have hit the starvation limit are offered first so they cannot lose.
  if (c_PRIO) begin : g_prio
    logic [NUM_INPUTS-1:0] w_aged;
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_aged
      assign w_aged[gi] = w_valid[gi] && (r_age[gi] == c_AGE_MAX);
    end
    assign w_pick_req = (|w_aged) ? w_aged : w_valid;
    assign w_pick_ptr = '0;
  end else begin : g_rr
    assign w_pick_req = w_valid;
    assign w_pick_ptr = r_ptr;
  end

  cbus_rr_arbiter_rr_pick #(
    .N     (NUM_INPUTS),
    .IDX_W (c_IDX_W)
  ) u_pick (
    .req    (w_pick_req),
    .ptr    (w_pick_ptr),
    .any    (w_win_any),
    .onehot (w_win_onehot),
    .idx    (w_win_idx)
  );

  assign w_locked      = (r_state == LOCKED);
  assign w_done        = oresp.ready && oresp.last;
  assign w_owner_valid = ireqs[r_owner].valid;

  // In IDLE the combinational winner owns the bus this cycle; in LOCKED the
  // latched owner does. Release always refers to whichever is current.
  assign w_sel_idx    = w_locked ? r_owner       : w_win_idx;
  assign w_sel_start  = w_locked ? r_start_valid : w_valid;
  assign w_sel_active = w_locked || w_win_any;
  assign w_release    = w_locked ? (w_done || !w_owner_valid)
                                 : (w_win_any && w_done);

  // An abort needs no explicit valid override: oreq mirrors the owner's
  // request, whose valid is already low in that cycle.
  always_comb begin
    oreq  = '0;
    grant = '0;
    busy  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (reset && w_sel_active) begin
      oreq              = ireqs[w_sel_idx];
      grant             = w_locked ? (NUM_INPUTS'(1) << r_owner) : w_win_onehot;
      iresps[w_sel_idx] = oresp;
    end
    busy = reset && w_locked;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_ptr         <= '0;
      r_start_valid <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          // A single-beat transfer completes in IDLE and never locks.
          if (w_win_any && !w_done) begin
            r_state       <= LOCKED;
            r_owner       <= w_win_idx;
            r_start_valid <= w_valid;
          end
        end
        LOCKED: begin
          if (w_done || !w_owner_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_release) begin
        r_ptr <= c_IDX_W'(wrap_inc(int'(w_sel_idx), NUM_INPUTS));
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (c_IDX_W'(i) == w_sel_idx) begin
            r_age[i] <= '0;
          end else if (w_sel_start[i] && (r_age[i] != c_AGE_MAX)) begin
            r_age[i] <= r_age[i] + c_AGE_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbus_rr_arbiter
//  Purpose  : Directed scoreboard bench for cbus_rr_arbiter. Three instances:
//             A = 2 inputs round-robin, B = 3 inputs priority/aging (limit 2),
//             C = 3 inputs round-robin. The driver pushes the hand-derived
//             expected outputs per cycle; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  cbus_req_t  req_a [2];
  cbus_resp_t resp_a [2];
  cbus_req_t  oreq_a;
  cbus_resp_t oresp_a;
  logic [1:0] grant_a;
  logic       busy_a;

  cbus_req_t  req_b [3];
  cbus_resp_t resp_b [3];
  cbus_req_t  oreq_b;
  cbus_resp_t oresp_b;
  logic [2:0] grant_b;
  logic       busy_b;

  cbus_req_t  req_c [3];
  cbus_resp_t resp_c [3];
  cbus_req_t  oreq_c;
  cbus_resp_t oresp_c;
  logic [2:0] grant_c;
  logic       busy_c;

  cbus_rr_arbiter #(.NUM_INPUTS(2), .MODE(0), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset), .ireqs(req_a), .iresps(resp_a),
    .oreq(oreq_a), .oresp(oresp_a), .grant(grant_a), .busy(busy_a));

  cbus_rr_arbiter #(.NUM_INPUTS(3), .MODE(1), .STARVE_LIMIT(2)) dut_b (
    .clk(clk), .reset(reset), .ireqs(req_b), .iresps(resp_b),
    .oreq(oreq_b), .oresp(oresp_b), .grant(grant_b), .busy(busy_b));

  cbus_rr_arbiter #(.NUM_INPUTS(3), .MODE(0), .STARVE_LIMIT(4)) dut_c (
    .clk(clk), .reset(reset), .ireqs(req_c), .iresps(resp_c),
    .oreq(oreq_c), .oresp(oresp_c), .grant(grant_c), .busy(busy_c));

  typedef struct packed {
    logic [63:0] name;
    logic [1:0]  dut;
    logic [2:0]  grant;
    logic        busy;
    logic        ov;
    logic [31:0] addr;
    logic [2:0]  irdy;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------------------------------------------------------- helpers
  function automatic cbus_req_t mk(input int i, input bit v);
    cbus_req_t r;
    r = '0;
    if (v) begin
      r.valid = 1'b1;
      r.addr  = 32'h100 * (i + 1);
      r.wdata = 32'hA000 + i;
      r.wstrb = 4'hF;
    end
    return r;
  endfunction

  function automatic cbus_resp_t rsp(input bit rdy, input bit lst);
    cbus_resp_t r;
    r       = '0;
    r.ready = rdy;
    r.last  = lst;
    r.data  = 32'hD00D;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected oreq address follows from the expected grant: master i uses
  // address 0x100*(i+1) whenever it is valid.
  task automatic push(input logic [63:0] nm, input logic [1:0] d, input logic [2:0] g,
                      input logic b, input logic ov, input logic [2:0] irdy);
    exp_t e;
    e.name  = nm;
    e.dut   = d;
    e.grant = g;
    e.busy  = b;
    e.ov    = ov;
    e.irdy  = irdy;
    if (!ov)          e.addr = 32'h0;
    else if (g[0])    e.addr = 32'h100;
    else if (g[1])    e.addr = 32'h200;
    else              e.addr = 32'h300;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] nm, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t       mon_e;
  logic [2:0] a_grant;
  logic       a_busy;
  logic       a_ov;
  logic [31:0] a_addr;
  logic [2:0] a_irdy;

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        case (mon_e.dut)
          2'd0: begin
            a_grant = {1'b0, grant_a};
            a_busy  = busy_a;
            a_ov    = oreq_a.valid;
            a_addr  = oreq_a.addr;
            a_irdy  = {1'b0, resp_a[1].ready, resp_a[0].ready};
          end
          2'd1: begin
            a_grant = grant_b;
            a_busy  = busy_b;
            a_ov    = oreq_b.valid;
            a_addr  = oreq_b.addr;
            a_irdy  = {resp_b[2].ready, resp_b[1].ready, resp_b[0].ready};
          end
          default: begin
            a_grant = grant_c;
            a_busy  = busy_c;
            a_ov    = oreq_c.valid;
            a_addr  = oreq_c.addr;
            a_irdy  = {resp_c[2].ready, resp_c[1].ready, resp_c[0].ready};
          end
        endcase
        chk(mon_e.name, "grant", 32'(a_grant), 32'(mon_e.grant));
        chk(mon_e.name, "busy",  32'(a_busy),  32'(mon_e.busy));
        chk(mon_e.name, "oreq_v", 32'(a_ov),   32'(mon_e.ov));
        chk(mon_e.name, "oreq_a", a_addr,      mon_e.addr);
        chk(mon_e.name, "iresp_rdy", 32'(a_irdy), 32'(mon_e.irdy));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  task automatic clear_all();
    for (int i = 0; i < 2; i++) req_a[i] = '0;
    for (int i = 0; i < 3; i++) req_b[i] = '0;
    for (int i = 0; i < 3; i++) req_c[i] = '0;
    oresp_a = '0;
    oresp_b = '0;
    oresp_c = '0;
  endtask

  initial begin
    reset = 1'b0;
    clear_all();

    // Outputs masked while reset is low, even with a live request.
    tick();
    req_a[0] = mk(0, 1); oresp_a = rsp(1, 0);
    push("rst", 0, 3'b000, 0, 0, 3'b000);

    // ---- A: single master 4-beat burst
    tick(); reset = 1'b1;
    push("burst0", 0, 3'b001, 0, 1, 3'b001);
    tick(); push("burst1", 0, 3'b001, 1, 1, 3'b001);
    tick(); push("burst2", 0, 3'b001, 1, 1, 3'b001);
    tick(); oresp_a = rsp(1, 1);
    push("burst3", 0, 3'b001, 1, 1, 3'b001);
    tick(); clear_all();
    push("bidle", 0, 3'b000, 0, 0, 3'b000);

    // ---- A: two masters, single-beat, pointer now 1 -> 1,0,1,0
    tick(); req_a[0] = mk(0, 1); req_a[1] = mk(1, 1); oresp_a = rsp(1, 1);
    push("alt0", 0, 3'b010, 0, 1, 3'b010);
    tick(); push("alt1", 0, 3'b001, 0, 1, 3'b001);
    tick(); push("alt2", 0, 3'b010, 0, 1, 3'b010);
    tick(); push("alt3", 0, 3'b001, 0, 1, 3'b001);
    tick(); clear_all();
    push("aidle", 0, 3'b000, 0, 0, 3'b000);

    // ---- A: owner 1 aborts mid-burst, waiting master 0 takes over
    tick(); req_a[0] = mk(0, 1); req_a[1] = mk(1, 1); oresp_a = rsp(1, 0);
    push("abt0", 0, 3'b010, 0, 1, 3'b010);
    tick(); push("abt1", 0, 3'b010, 1, 1, 3'b010);
    tick(); req_a[1] = mk(1, 0);
    push("abt2", 0, 3'b010, 1, 0, 3'b010);
    tick(); oresp_a = rsp(1, 1);
    push("abt3", 0, 3'b001, 0, 1, 3'b001);
    tick(); clear_all();
    push("abidle", 0, 3'b000, 0, 0, 3'b000);

    // ---- A: reset while locked (pointer was 1; reset returns it to 0)
    tick(); req_a[0] = mk(0, 1); oresp_a = rsp(1, 0);
    push("rl0", 0, 3'b001, 0, 1, 3'b001);
    tick(); push("rl1", 0, 3'b001, 1, 1, 3'b001);
    tick(); reset = 1'b0;
    push("rl_rst", 0, 3'b000, 0, 0, 3'b000);
    tick(); reset = 1'b1; req_a[1] = mk(1, 1); oresp_a = rsp(1, 1);
    push("rl_post", 0, 3'b001, 0, 1, 3'b001);
    tick(); clear_all();
    push("rlidle", 0, 3'b000, 0, 0, 3'b000);

    // ---- B: priority with aging, inputs 0 and 2 always valid
    tick(); req_b[0] = mk(0, 1); req_b[2] = mk(2, 1); oresp_b = rsp(1, 1);
    push("age0", 1, 3'b001, 0, 1, 3'b001);
    tick(); push("age1", 1, 3'b001, 0, 1, 3'b001);
    tick(); push("age2", 1, 3'b100, 0, 1, 3'b100);
    tick(); push("age3", 1, 3'b001, 0, 1, 3'b001);
    tick(); push("age4", 1, 3'b001, 0, 1, 3'b001);
    tick(); push("age5", 1, 3'b100, 0, 1, 3'b100);
    tick(); clear_all();
    push("ageidle", 1, 3'b000, 0, 0, 3'b000);

    // ---- C: owner 1, last beat coincides with new requests from 0 and 2
    tick(); req_c[1] = mk(1, 1); oresp_c = rsp(1, 0);
    push("c3_0", 2, 3'b010, 0, 1, 3'b010);
    tick(); req_c[0] = mk(0, 1); req_c[2] = mk(2, 1); oresp_c = rsp(1, 1);
    push("c3_1", 2, 3'b010, 1, 1, 3'b010);
    tick(); req_c[1] = mk(1, 0);
    push("c3_2", 2, 3'b100, 0, 1, 3'b100);
    tick(); push("c3_3", 2, 3'b001, 0, 1, 3'b001);
    tick(); push("c3_4", 2, 3'b100, 0, 1, 3'b100);
    tick(); clear_all();
    push("c3idle", 2, 3'b000, 0, 0, 3'b000);

    tick();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
